// File: rtl/game_pkg.sv
// game_pkg: encodings shared by the move arbiter, the game controller and the AI.
//   DIR_*   : 3-bit move command codes (DIR_NONE means "no move this cycle")
//   SRC_*   : 2-bit grant source codes reported by the arbiter
//   arb_state_e : move_arbiter FSM states
//   btn_to_dir  : fixed-priority encoder for simultaneous button pulses
//   max3        : elaboration-time helper used to size the shared counter
package game_pkg;

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_RIGHT = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_BTN  = 2'd1;
  localparam logic [1:0] SRC_UART = 2'd2;
  localparam logic [1:0] SRC_AI   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COOLDOWN  = 3'd4,
    ST_RESET     = 3'd5
  } arb_state_e;

  // Simultaneous presses resolve up > right > down > left.
  function automatic logic [1:0] btn_to_dir(input logic up, input logic right,
                                            input logic down, input logic left);
    logic [1:0] d;
    d = 2'd3;
    if (up) begin
      d = 2'd0;
    end else if (right) begin
      d = 2'd1;
    end else if (down) begin
      d = 2'd2;
    end else if (left) begin
      d = 2'd3;
    end else begin
      d = 2'd3;
    end
    return d;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/move_arbiter.sv
// move_arbiter: arbitrates direction requests from buttons, UART and AI into
// single-cycle move commands for the game controller, waits for the
// controller's busy handshake, enforces a cooldown, and turns new-game
// requests into a timed game reset pulse.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_btn_up/right/down/left single-cycle debounced direction presses
//   i_btn_new               single-cycle debounced new-game press
//   i_uart_valid/i_uart_dir, o_uart_ready   UART request handshake
//   i_ai_en, i_ai_valid/i_ai_dir, o_ai_ready AI request handshake
//   i_ctrl_busy             game controller is processing a move
//   o_dir                   move command (DIR_NONE except in ISSUE)
//   o_game_rst              game controller reset pulse
//   o_src                   source of the last grant
//   o_timeout               one-cycle pulse when a move is abandoned
//   o_move_count            saturating count of issued moves
module move_arbiter
  import game_pkg::*;
#(
  parameter int TIMEOUT    = 1024,
  parameter int COOLDOWN   = 16,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn_up,
  input  logic             i_btn_right,
  input  logic             i_btn_down,
  input  logic             i_btn_left,
  input  logic             i_btn_new,
  input  logic             i_uart_valid,
  input  logic [1:0]       i_uart_dir,
  output logic             o_uart_ready,
  input  logic             i_ai_en,
  input  logic             i_ai_valid,
  input  logic [1:0]       i_ai_dir,
  output logic             o_ai_ready,
  input  logic             i_ctrl_busy,
  output logic [2:0]       o_dir,
  output logic             o_game_rst,
  output logic [1:0]       o_src,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_move_count
);

  // One down-counter serves RESET, WAIT_ACK and COOLDOWN; it only ever holds
  // (duration - 1) down to zero, so log2 of the longest duration is enough.
  localparam int MAX_CNT = max3(TIMEOUT, COOLDOWN, RST_CYCLES);
  localparam int CW      = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

  arb_state_e       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_btn_pend;
  logic [1:0]       r_btn_dir;
  logic             r_new_pend;

  logic             w_btn_press;
  logic [1:0]       w_press_dir;
  logic             w_btn_avail;
  logic [1:0]       w_btn_dir;
  logic             w_can_grant;
  logic             w_grant;
  logic             w_grant_btn;
  logic [2:0]       w_grant_dir;
  logic [1:0]       w_grant_src;
  logic [CNT_W-1:0] w_count_next;

  // Button view: a press this cycle counts as pending immediately, and a
  // newer press overrides whatever is already latched.
  always_comb begin
    w_btn_press = i_btn_up | i_btn_right | i_btn_down | i_btn_left;
    w_press_dir = btn_to_dir(i_btn_up, i_btn_right, i_btn_down, i_btn_left);
    if (w_btn_press) begin
      w_btn_avail = 1'b1;
      w_btn_dir   = w_press_dir;
    end else begin
      w_btn_avail = r_btn_pend;
      w_btn_dir   = r_btn_dir;
    end
  end

  // Grant selection and ready outputs; a pending new game blocks all grants.
  always_comb begin
    w_can_grant = (r_state == ST_IDLE) && !r_new_pend;
    w_grant     = 1'b0;
    w_grant_btn = 1'b0;
    w_grant_dir = DIR_NONE;
    w_grant_src = SRC_NONE;
    if (w_can_grant) begin
      if (w_btn_avail) begin
        w_grant     = 1'b1;
        w_grant_btn = 1'b1;
        w_grant_dir = {1'b0, w_btn_dir};
        w_grant_src = SRC_BTN;
      end else if (i_uart_valid) begin
        w_grant     = 1'b1;
        w_grant_dir = {1'b0, i_uart_dir};
        w_grant_src = SRC_UART;
      end else if (i_ai_en && i_ai_valid) begin
        w_grant     = 1'b1;
        w_grant_dir = {1'b0, i_ai_dir};
        w_grant_src = SRC_AI;
      end else begin
        w_grant = 1'b0;
      end
    end else begin
      w_grant = 1'b0;
    end
    // Gated by i_rst so the readies read 0 while reset is held.
    o_uart_ready = !i_rst && w_can_grant && !w_btn_avail;
    o_ai_ready   = o_uart_ready && i_ai_en && !i_uart_valid;
  end

  // Saturating move counter increment.
  always_comb begin
    if (o_move_count == {CNT_W{1'b1}}) begin
      w_count_next = o_move_count;
    end else begin
      w_count_next = o_move_count + CNT_W'(1);
    end
  end

  // Arbiter FSM, request latches and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= {CW{1'b0}};
      r_btn_pend   <= 1'b0;
      r_btn_dir    <= 2'd0;
      r_new_pend   <= 1'b0;
      o_dir        <= DIR_NONE;
      o_game_rst   <= 1'b0;
      o_src        <= SRC_NONE;
      o_timeout    <= 1'b0;
      o_move_count <= {CNT_W{1'b0}};
    end else begin
      o_dir      <= DIR_NONE;
      o_timeout  <= 1'b0;
      o_game_rst <= 1'b0;

      // Inputs are ignored while the game is being reset.
      if (r_state != ST_RESET) begin
        if (w_grant_btn) begin
          r_btn_pend <= 1'b0;
        end else if (w_btn_press) begin
          r_btn_pend <= 1'b1;
          r_btn_dir  <= w_press_dir;
        end
        if (i_btn_new) begin
          r_new_pend <= 1'b1;
        end
      end

      if (r_new_pend) begin
        // New game preempts whatever is in flight, including a half-done move.
        r_state      <= ST_RESET;
        r_cnt        <= CW'(RST_CYCLES - 1);
        o_game_rst   <= 1'b1;
        r_btn_pend   <= 1'b0;
        r_new_pend   <= 1'b0;
        o_move_count <= {CNT_W{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_grant) begin
              r_state      <= ST_ISSUE;
              o_dir        <= w_grant_dir;
              o_src        <= w_grant_src;
              o_move_count <= w_count_next;
            end
          end
          ST_ISSUE: begin
            r_state <= ST_WAIT_ACK;
            r_cnt   <= CW'(TIMEOUT - 1);
          end
          ST_WAIT_ACK: begin
            if (i_ctrl_busy) begin
              r_state <= ST_WAIT_DONE;
            end else if (r_cnt == {CW{1'b0}}) begin
              // TIMEOUT cycles in WAIT_ACK without busy: give the move up.
              o_timeout <= 1'b1;
              if (COOLDOWN == 0) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_COOLDOWN;
                r_cnt   <= CW'(COOLDOWN - 1);
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_WAIT_DONE: begin
            if (!i_ctrl_busy) begin
              if (COOLDOWN == 0) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_COOLDOWN;
                r_cnt   <= CW'(COOLDOWN - 1);
              end
            end
          end
          ST_COOLDOWN: begin
            if (r_cnt == {CW{1'b0}}) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          ST_RESET: begin
            if (r_cnt == {CW{1'b0}}) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt      <= r_cnt - CW'(1);
              o_game_rst <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/move_arbiter.md
Name: move_arbiter

Overview:
- Sits between the input sources and the game controller.
- Arbitrates direction requests from three sources: debounced buttons, the UART receiver and the AI engine.
- Issues exactly one single-cycle move command per accepted request, then waits for the game controller's busy handshake before accepting the next move.
- Also sequences new-game requests into a timed game reset pulse.

Parameters:
- TIMEOUT, 1024: max cycles in WAIT_ACK for ctrl_busy to rise before the move is abandoned.
- COOLDOWN, 16: idle cycles enforced after each completed move before the next grant.
- RST_CYCLES, 4: length of the game_rst pulse, in cycles.
- CNT_W, 16: width of move_count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_up, btn_right, btn_down, btn_left  in  1 each  single-cycle debounced press pulses
- btn_new  in  1  single-cycle debounced new-game pulse
- uart_valid  in  1  UART direction request valid
- uart_dir  in  2  UART direction, 0 up, 1 right, 2 down, 3 left
- uart_ready  out  1  UART request accepted when uart_valid & uart_ready
- ai_en  in  1  AI source enable
- ai_valid  in  1  AI direction request valid
- ai_dir  in  2  AI direction, same encoding as uart_dir
- ai_ready  out  1  AI request accepted when ai_valid & ai_ready
- ctrl_busy  in  1  game controller is processing a move
- dir  out  3  move command to game controller: 0 up, 1 right, 2 down, 3 left, 4 none
- game_rst  out  1  game controller reset pulse
- src  out  2  source of last grant: 0 none, 1 button, 2 uart, 3 ai
- timeout  out  1  one-cycle pulse when a move is abandoned in WAIT_ACK
- move_count  out  CNT_W  number of moves issued since the last reset or new game

Behaviour:
- Reset (async, rst=1):
  - State IDLE; dir=4; game_rst=0; src=0; timeout=0; move_count=0.
  - uart_ready=0 and ai_ready=0; button and new-game pending latches cleared.
- Button latch:
  - A one-deep pending register captures presses in any state except RESET; a newer press overwrites an older pending one.
  - Simultaneous pulses resolve up > right > down > left.
- New-game latch: a btn_new pulse in any state sets new_pend.
- State RESET:
  - Entered on the cycle after new_pend is set, from any state, including mid-move.
  - game_rst=1 for exactly RST_CYCLES cycles; dir=4.
  - Button latch, new_pend and move_count are cleared on entry.
  - Button presses and btn_new pulses during RESET are ignored.
  - Exits to IDLE.
- Grant priority in IDLE: new_pend > button pending > uart_valid > (ai_en & ai_valid).
- Ready signals (combinational, IDLE only):
  - uart_ready = IDLE & !new_pend & !btn_pend.
  - ai_ready = IDLE & ai_en & !new_pend & !btn_pend & !uart_valid.
  - At most one source is accepted per cycle.
- IDLE -> ISSUE on a grant. The accepted dir is registered; src is updated; the consumed button latch is cleared.
- ISSUE:
  - dir = granted direction for exactly 1 cycle (grant-to-dir latency: 1 cycle).
  - move_count increments, saturating at all-ones.
  - Next state: WAIT_ACK.
- WAIT_ACK:
  - dir=4.
  - ctrl_busy=1 -> WAIT_DONE.
  - After TIMEOUT cycles without busy: pulse timeout for 1 cycle, then -> COOLDOWN.
- WAIT_DONE: ctrl_busy=0 -> COOLDOWN. No timeout applies in this state.
- COOLDOWN: counts COOLDOWN cycles -> IDLE. With COOLDOWN=0, go directly to IDLE.
- dir=4 in every state except ISSUE.
- ai_en deasserting mid-move does not cancel an already granted AI move.

Decomposition:
- Shared package game_pkg holds:
  - DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3, DIR_NONE=4 (3-bit), also used by the game controller and AI.
  - SRC_NONE/SRC_BTN/SRC_UART/SRC_AI codes.
  - The move_arbiter state enum: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, COOLDOWN, RESET.
- The block is a single flat FSM with one shared down-counter reused across RESET, WAIT_ACK and COOLDOWN; no sub-module is needed.

Test Plan:
1. btn_right pulse in IDLE, ctrl_busy high for 5 cycles starting 2 cycles after ISSUE -> dir=1 for exactly 1 cycle, src=1, move_count=1, next grant not before COOLDOWN cycles after busy falls.
2. Same cycle: btn_left pulse, uart_valid=1 uart_dir=0, ai_en=1 ai_valid=1 -> button wins, dir=3, uart_ready=0; after cooldown uart wins with dir=0; AI is served third.
3. btn_up then btn_down pulses during WAIT_DONE -> only dir=2 is issued after cooldown; the up press is discarded.
4. ctrl_busy held 0 after ISSUE -> timeout pulses exactly TIMEOUT cycles later, then COOLDOWN, then IDLE; move_count still increments.
5. btn_new asserted while in WAIT_DONE -> game_rst high 4 cycles, move_count=0, pending button cleared, dir=4 throughout; FSM returns to IDLE.
6. rst asserted mid-ISSUE without a clock edge -> dir=4 and all outputs at reset values immediately; ai_en=0 with ai_valid=1 -> ai_ready stays 0 and no move issues.
